// File: rtl/serdes_sync_mon.sv
// serdes_sync_mon: fast-clock monitor for the SERDES word-sync strobe.
// Predicts the word slot, qualifies lock and counts sync errors while locked.
module serdes_sync_mon #(
  parameter int RATIO      = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sync,
  input  logic                     i_err_clr,
  output logic [$clog2(RATIO)-1:0] o_phase,
  output logic                     o_phase_first,
  output logic                     o_locked,
  output logic                     o_err_pulse,
  output logic [ERR_W-1:0]         o_err_cnt
);

  localparam int PW = $clog2(RATIO);
  localparam logic [PW-1:0]    PHASE_LAST  = PW'(RATIO - 1);
  localparam logic [PW-1:0]    PHASE_ONE   = PW'(1);
  localparam logic [7:0]       GOOD_TARGET = 8'(LOCK_CNT);
  localparam logic [3:0]       BAD_TARGET  = 4'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [7:0]       r_goodCnt;
  logic [3:0]       r_badCnt;
  logic             r_phaseFirst;
  logic             r_locked;
  logic             r_errPulse;
  logic [ERR_W-1:0] r_errCnt;

  logic             w_expected;
  logic             w_good;
  logic             w_early;
  logic             w_miss;
  logic             w_errEvent;
  logic [PW-1:0]    w_phaseInc;
  logic [7:0]       w_goodNext;
  logic [3:0]       w_badNext;

  // A slot is expected only once some sync has anchored the phase.
  assign w_expected = (r_state != HUNT) && (r_phase == '0);
  assign w_good     = i_sync && w_expected;
  assign w_early    = i_sync && !w_expected;
  assign w_miss     = !i_sync && w_expected;
  assign w_errEvent = (r_state == LOCKED) && (w_early || w_miss);
  assign w_phaseInc = (r_phase == PHASE_LAST) ? '0 : r_phase + PHASE_ONE;
  assign w_goodNext = r_goodCnt + 8'd1;
  assign w_badNext  = r_badCnt + 4'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= HUNT;
      r_phase      <= '0;
      r_goodCnt    <= '0;
      r_badCnt     <= '0;
      r_phaseFirst <= 1'b0;
      r_locked     <= 1'b0;
      r_errPulse   <= 1'b0;
      r_errCnt     <= '0;
    end else begin
      r_errPulse <= w_errEvent;
      if (i_err_clr) begin
        r_errCnt <= '0;
      end else if (w_errEvent && (r_errCnt != ERR_MAX)) begin
        r_errCnt <= r_errCnt + ERR_ONE;
      end

      case (r_state)
        HUNT: begin
          r_phaseFirst <= 1'b0;
          r_locked     <= 1'b0;
          r_badCnt     <= '0;
          if (i_sync) begin
            r_state   <= VERIFY;
            r_goodCnt <= '0;
            r_phase   <= PHASE_ONE;
          end else begin
            r_phase <= '0;
          end
        end

        VERIFY: begin
          if (w_good) begin
            r_phase      <= w_phaseInc;
            r_phaseFirst <= (w_phaseInc == '0);
            if (w_goodNext == GOOD_TARGET) begin
              r_state   <= LOCKED;
              r_locked  <= 1'b1;
              r_badCnt  <= '0;
              r_goodCnt <= '0;
            end else begin
              r_goodCnt <= w_goodNext;
            end
          end else if (w_early) begin
            r_phase      <= PHASE_ONE;
            r_phaseFirst <= 1'b0;
            r_goodCnt    <= '0;
          end else if (w_miss) begin
            r_state      <= HUNT;
            r_phase      <= '0;
            r_phaseFirst <= 1'b0;
            r_goodCnt    <= '0;
          end else begin
            r_phase      <= w_phaseInc;
            r_phaseFirst <= (w_phaseInc == '0);
          end
        end

        LOCKED: begin
          // Once locked, stray syncs never move the phase; only losing lock resets it.
          if ((w_early || w_miss) && (w_badNext == BAD_TARGET)) begin
            r_state      <= HUNT;
            r_phase      <= '0;
            r_phaseFirst <= 1'b0;
            r_locked     <= 1'b0;
            r_badCnt     <= '0;
          end else begin
            r_phase      <= w_phaseInc;
            r_phaseFirst <= (w_phaseInc == '0);
            if (w_good) begin
              r_badCnt <= '0;
            end else if (w_early || w_miss) begin
              r_badCnt <= w_badNext;
            end
          end
        end

        default: begin
          r_state <= HUNT;
        end
      endcase
    end
  end

  assign o_phase       = r_phase;
  assign o_phase_first = r_phaseFirst;
  assign o_locked      = r_locked;
  assign o_err_pulse   = r_errPulse;
  assign o_err_cnt     = r_errCnt;

endmodule

// File: tb/tb_serdes_sync_mon.sv
// tb_serdes_sync_mon: vector table, directed corner sequences and a randomized
// run checked against a timestamp-based model of the sync monitor.
module tb_serdes_sync_mon;

  localparam int RATIO      = 4;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 2;
  localparam int ERR_W      = 2;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic             clk    = 1'b0;
  logic             rstN   = 1'b0;
  logic             syncIn = 1'b0;
  logic             errClr = 1'b0;
  logic [1:0]       phase;
  logic             phaseFirst;
  logic             locked;
  logic             errPulse;
  logic [ERR_W-1:0] errCnt;

  serdes_sync_mon #(
    .RATIO(RATIO), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(ERR_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_sync(syncIn), .i_err_clr(errClr),
    .o_phase(phase), .o_phase_first(phaseFirst), .o_locked(locked),
    .o_err_pulse(errPulse), .o_err_cnt(errCnt)
  );

  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int edgeIdx = 0;

  // Model: mode 0=hunt 1=verify 2=locked; phase derived from the edge index of the last aligning sync.
  int mMode = 0, mAnchor = 0, mGood = 0, mBad = 0, mErr = 0, mPhase = 0;
  bit mPulse = 0, mFirst = 0, mLocked = 0;

  function automatic void modelEdge(bit s, bit clr, bit rn, int e);
    int  cur;
    bit  expd, good, early, miss, ev;
    if (!rn) begin
      mMode = 0; mGood = 0; mBad = 0; mErr = 0; mPhase = 0;
      mPulse = 0; mFirst = 0; mLocked = 0;
      return;
    end
    cur   = (mMode == 0) ? 0 : ((e - mAnchor) % RATIO);
    expd  = (mMode != 0) && (cur == 0);
    good  = s && expd;
    early = s && !expd;
    miss  = !s && expd;
    ev    = 0;
    if (mMode == 0) begin
      if (s) begin mMode = 1; mGood = 0; mAnchor = e; end
    end else if (mMode == 1) begin
      if (good) begin
        mGood++;
        if (mGood == LOCK_CNT) begin mMode = 2; mBad = 0; end
      end else if (early) begin
        mAnchor = e; mGood = 0;
      end else if (miss) begin
        mMode = 0;
      end
    end else begin
      if (good) mBad = 0;
      else if (early || miss) begin
        ev = 1;
        mBad++;
        if (mBad == UNLOCK_CNT) begin mMode = 0; mBad = 0; end
      end
    end
    mPulse = ev;
    if (clr) mErr = 0;
    else if (ev && mErr < ERR_MAX) mErr++;
    mPhase  = (mMode == 0) ? 0 : ((e + 1 - mAnchor) % RATIO);
    mFirst  = (mMode != 0) && (mPhase == 0);
    mLocked = (mMode == 2);
  endfunction

  task automatic checkVal(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edgeIdx);
    end
  endtask

  task automatic checkOutput(string tag, int ph, bit pf, bit lk, bit pu, int er);
    checkVal({tag, ".phase"},       32'(phase),      32'(ph));
    checkVal({tag, ".phase_first"}, 32'(phaseFirst), 32'(pf));
    checkVal({tag, ".locked"},      32'(locked),     32'(lk));
    checkVal({tag, ".err_pulse"},   32'(errPulse),   32'(pu));
    checkVal({tag, ".err_cnt"},     32'(errCnt),     32'(er));
  endtask

  task automatic applyStimulus(bit s, bit clr, bit rn);
    syncIn = s;
    errClr = clr;
    rstN   = rn;
    @(posedge clk);
    #1;
    modelEdge(s, clr, rn, edgeIdx);
    edgeIdx++;
    checkOutput("model", mPhase, mFirst, mLocked, mPulse, mErr);
  endtask

  task automatic runSyncs(int n, int period);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int j = 0; j < period - 1; j++) applyStimulus(1'b0, 1'b0, 1'b1);
    end
  endtask

  typedef struct {
    bit sync; bit clr; bit rstn;
    int ph; bit pf; bit lk; bit pu; int er;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int g;
    bit s;
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 2, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 3, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 2, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 2, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 1, 3, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 1, 0, 0, 0};
    vecs[13] = '{1, 0, 1, 1, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 1, 2, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 3, 0, 0, 0, 0};

    #1;
    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].sync, vecs[i].clr, vecs[i].rstn);
      checkOutput($sformatf("vec%0d", i), vecs[i].ph, vecs[i].pf, vecs[i].lk, vecs[i].pu, vecs[i].er);
    end

    $display("[TB] lock from reset");
    applyStimulus(0, 0, 0);
    runSyncs(8, 4);
    checkVal("lock.before", 32'(locked), 0);
    applyStimulus(1, 0, 1);
    checkVal("lock.after", 32'(locked), 1);
    checkVal("lock.phase", 32'(phase), 1);
    repeat (3) applyStimulus(0, 0, 1);
    checkVal("lock.first", 32'(phaseFirst), 1);
    checkVal("lock.err", 32'(errCnt), 0);

    $display("[TB] single missing sync");
    applyStimulus(0, 0, 1);
    checkVal("miss1.pulse", 32'(errPulse), 1);
    checkVal("miss1.err", 32'(errCnt), 1);
    checkVal("miss1.locked", 32'(locked), 1);
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    checkVal("miss1.goodPulse", 32'(errPulse), 0);
    checkVal("miss1.errHeld", 32'(errCnt), 1);
    applyStimulus(0, 1, 1);
    checkVal("clr.err", 32'(errCnt), 0);
    repeat (2) applyStimulus(0, 0, 1);

    $display("[TB] two missing syncs");
    applyStimulus(0, 0, 1);
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkVal("miss2.locked", 32'(locked), 0);
    checkVal("miss2.phase", 32'(phase), 0);
    checkVal("miss2.err", 32'(errCnt), 2);
    repeat (2) applyStimulus(0, 0, 1);
    runSyncs(8, 4);
    checkVal("relock.before", 32'(locked), 0);
    applyStimulus(1, 0, 1);
    checkVal("relock.after", 32'(locked), 1);
    repeat (3) applyStimulus(0, 0, 1);

    $display("[TB] error saturation");
    applyStimulus(1, 0, 1);
    applyStimulus(0, 1, 1);
    repeat (2) applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1);
      repeat (3) applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 1);
      repeat (3) applyStimulus(0, 0, 1);
    end
    checkVal("sat.err", 32'(errCnt), 3);
    checkVal("sat.locked", 32'(locked), 1);
    applyStimulus(0, 1, 1);
    checkVal("clrEv.err", 32'(errCnt), 0);
    checkVal("clrEv.pulse", 32'(errPulse), 1);
    checkVal("clrEv.locked", 32'(locked), 1);
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    repeat (3) applyStimulus(0, 0, 1);

    $display("[TB] reset while locked");
    applyStimulus(0, 0, 0);
    checkOutput("midReset", 0, 0, 0, 0, 0);
    runSyncs(8, 4);
    checkVal("midReset.before", 32'(locked), 0);
    applyStimulus(1, 0, 1);
    checkVal("midReset.relock", 32'(locked), 1);

    $display("[TB] realign in verify");
    applyStimulus(0, 0, 0);
    runSyncs(3, 4);
    applyStimulus(0, 0, 1);
    checkVal("realign.hunt", 32'(phase), 0);
    applyStimulus(1, 0, 1);
    checkVal("realign.phase", 32'(phase), 1);
    checkVal("realign.err", 32'(errCnt), 0);
    repeat (3) applyStimulus(0, 0, 1);
    runSyncs(7, 4);
    checkVal("realign.before", 32'(locked), 0);
    applyStimulus(1, 0, 1);
    checkVal("realign.locked", 32'(locked), 1);

    $display("[TB] randomized run");
    applyStimulus(0, 0, 0);
    g = 0;
    for (int i = 0; i < 3000; i++) begin
      s = (g % RATIO == 0);
      if ($urandom_range(0, 19) == 0) s = !s;
      if ($urandom_range(0, 49) == 0) g++;
      g++;
      applyStimulus(s, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
